// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulation sequencer.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  localparam int ACC_WIDTH = 32;
  localparam int ACC_LEN_W = 16;

endpackage

// File: rtl/acc_core.sv
// Registered wrapping accumulator with a sticky carry-out flag.
module acc_core
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] add_full;

  always_comb begin
    add_full = {1'b0, sum} + {1'b0, din};
  end

  // clr wins over en so an abort discards a same-cycle operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      sum <= add_full[WIDTH-1:0];
      ovf <= ovf | add_full[WIDTH];
    end
  end

endmodule

// File: rtl/acc_seq.sv
// Accumulation sequencer: descriptor in, counted operand stream, held result out.
//
//   state | meaning
//   IDLE  | waiting for a job descriptor (cfg_ready)
//   ACCUM | taking operands until the remaining count reaches zero (in_ready)
//   DONE  | presenting the sum until the consumer takes it (out_valid)
module acc_seq
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int LEN_W = ACC_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  acc_state_t       state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             cfg_hs, in_hs, abort_act, last_op;
  logic             acc_clr, acc_en;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_ovf;

  always_comb begin
    cfg_hs    = (state == IDLE) && cfg_valid;
    in_hs     = (state == ACCUM) && in_valid;
    abort_act = (state != IDLE) && abort;
    last_op   = (cnt == {{(LEN_W-1){1'b0}}, 1'b1});
    acc_clr   = cfg_hs || abort_act;
    acc_en    = in_hs && !abort_act;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_valid) state_nxt = (cfg_len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        if (abort)                    state_nxt = IDLE;
        else if (in_valid && last_op) state_nxt = DONE;
      end
      DONE: begin
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining-operand count; only loaded from a descriptor, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (abort_act) cnt <= '0;
    else if (cfg_hs)    cnt <= cfg_len;
    else if (in_hs)     cnt <= cnt - 1'b1;
  end

  acc_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (in_data),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  // Outputs depend only on registered state and accumulator contents.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ovf   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  cfg_ready = 1'b1;
      ACCUM: in_ready  = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc_sum;
        out_ovf   = acc_ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acc_seq.sv
// Randomized bench for acc_seq against a whole-job arithmetic reference.
module tb_acc_seq;
  import acc_pkg::*;

  localparam int W  = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready;
  logic [LW-1:0] cfg_len;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic          abort;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf, busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] ops [0:15];

  acc_seq #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
  endtask

  // Expected sum is the true (unbounded) total: low W bits are the result and
  // any carry out of the running sum shows up as a total of 2^W or more.
  task automatic run_job(input int len, input int gmin, input int gmax, input int hold);
    longint unsigned total;
    logic [W-1:0]    exp_data;
    logic            exp_ovf;
    int              g;
    total = 0;
    @(negedge clk);
    chk("cfg_ready_before_job", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_len   = LW'(len);
    @(negedge clk);
    cfg_valid = 1'b0;
    if (len == 0) begin
      chk("len0_out_valid", 64'(out_valid), 64'd1);
      chk("len0_in_ready",  64'(in_ready),  64'd0);
    end else begin
      chk("accum_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < len; i++) begin
        g = int'($urandom_range(gmax, gmin));
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          @(negedge clk);
          chk("stall_in_ready",  64'(in_ready),  64'd1);
          chk("stall_out_valid", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1;
        in_data  = ops[i];
        total    = total + 64'(ops[i]);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      chk("last_op_latency", 64'(out_valid), 64'd1);
      chk("done_in_ready",   64'(in_ready),  64'd0);
    end
    exp_data = total[W-1:0];
    exp_ovf  = (total >> W) != 0;
    chk("result_data", 64'(out_data), 64'(exp_data));
    chk("result_ovf",  64'(out_ovf),  64'(exp_ovf));
    if (hold > 0) begin
      cfg_valid = 1'b1;
      cfg_len   = 16'd3;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_data",      64'(out_data),  64'(exp_data));
      chk("hold_ovf",       64'(out_ovf),   64'(exp_ovf));
      chk("hold_cfg_ready", 64'(cfg_ready), 64'd0);
    end
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_idle("after_take");
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3; ops[3] = 32'd4;
    run_job(4, 0, 0, 0);
    run_job(0, 0, 0, 2);
    ops[0] = 32'hFFFF_FFFF; ops[1] = 32'h2;
    run_job(2, 0, 0, 0);
    ops[0] = 32'd5;
    run_job(1, 0, 0, 0);
    ops[0] = 32'd11; ops[1] = 32'd22; ops[2] = 32'd33;
    run_job(3, 3, 3, 5);

    // Abort in ACCUM together with the 3rd operand
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 32'h999; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check_idle("abort_accum");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_result", 64'(out_valid), 64'd0);
    end
    ops[0] = 32'd7;
    run_job(1, 0, 0, 0);

    // Abort while the result is held
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("abort_done_pre", 64'(out_valid), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_done");

    // Abort in IDLE must not block a same-cycle descriptor
    abort = 1'b1; cfg_valid = 1'b1; cfg_len = 16'd1;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    chk("idle_abort_ignored", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 32'd42;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_abort_data", 64'(out_data), 64'd42);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of ACCUM
    cfg_valid = 1'b1; cfg_len = 16'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b1; in_data = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("rst_accum");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_accum_release");

    // Reset while holding a result
    cfg_valid = 1'b1; cfg_len = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("rst_done_pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_idle("rst_done");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_done_release");

    for (int j = 0; j < 25; j++) begin
      int len;
      len = int'($urandom_range(8, 0));
      for (int i = 0; i < 16; i++)
        ops[i] = ($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(255, 0));
      run_job(len, 0, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
